mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// HI/LO multiply/divide unit for a MIPS-style pipeline. MULT/MULTU/DIV/DIVU
// compute their 64-bit result at the accepting edge and hold it in a pending
// register. HI/LO are updated only when a fixed-length busy countdown expires.
// MTHI/MTLO write HI/LO directly at the accepting edge and never raise Busy.
//
// Parameters
//   MULT_CYCLES  busy duration of MULT/MULTU (1..31)
//   DIV_CYCLES   busy duration of DIV/DIVU   (1..31)
//
// Ports
//   clk      clock, all state updates on the rising edge
//   reset    asynchronous active-low reset
//   Start    E-stage instruction is a valid MDU operation
//   MDUOp    0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   A, B     rs / rt operands (already forwarded)
//   ReadSel  MDOut source: 0 LO, 1 HI
//   Busy     multi-cycle operation in progress
//   MDOut    MFHI/MFLO read data, combinational from HI/LO
//   HI, LO   architectural HI/LO registers
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        ReadSel,
   output logic        Busy,
   output logic [31:0] MDOut,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   localparam logic [4:0] MultLoad = 5'(MULT_CYCLES);
   localparam logic [4:0] DivLoad  = 5'(DIV_CYCLES);

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] pend_q, pend_d;
   logic        pend_wr_q, pend_wr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   // -------------------------------------------------------------------------
   // Multiplier: extend both operands to 64 bits, the low 64 bits of the
   // product are then correct for both signed and unsigned interpretation.
   // -------------------------------------------------------------------------
   logic        mult_signed;
   logic [63:0] mult_a;
   logic [63:0] mult_b;
   logic [63:0] product;

   always_comb begin
      mult_signed = (MDUOp == OpMult);
      mult_a      = {{32{mult_signed & A[31]}}, A};
      mult_b      = {{32{mult_signed & B[31]}}, B};
      product     = mult_a * mult_b;
   end

   // -------------------------------------------------------------------------
   // Divider: divide magnitudes, then restore signs. Quotient is negative when
   // operand signs differ, remainder takes the sign of the dividend. Working
   // on magnitudes makes 0x80000000 / -1 wrap to 0x80000000 naturally.
   // -------------------------------------------------------------------------
   logic        div_signed;
   logic        a_neg;
   logic        b_neg;
   logic        div_by_zero;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] divisor;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   always_comb begin
      div_signed  = (MDUOp == OpDiv);
      a_neg       = div_signed & A[31];
      b_neg       = div_signed & B[31];
      div_by_zero = (B == 32'd0);
      a_mag       = a_neg ? (~A + 32'd1) : A;
      b_mag       = b_neg ? (~B + 32'd1) : B;
      // Substitute 1 so the divider never sees zero; the result is discarded.
      divisor     = div_by_zero ? 32'd1 : b_mag;
      q_mag       = a_mag / divisor;
      r_mag       = a_mag % divisor;
      quot        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem         = a_neg ? (~r_mag + 32'd1) : r_mag;
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      unique case (state_q)
         StIdle: begin
            if (Start) begin
               case (MDUOp)
                  OpMult, OpMultu: begin
                     state_d   = StMul;
                     cnt_d     = MultLoad;
                     pend_d    = product;
                     pend_wr_d = 1'b1;
                  end
                  OpDiv, OpDivu: begin
                     state_d   = StDiv;
                     cnt_d     = DivLoad;
                     pend_d    = {rem, quot};
                     // Divide by zero still runs the full duration but
                     // leaves HI/LO untouched at completion.
                     pend_wr_d = ~div_by_zero;
                  end
                  OpMthi:  hi_d = A;
                  OpMtlo:  lo_d = A;
                  default: ;
               endcase
            end
         end

         StMul, StDiv: begin
            // Count value 1 marks the last busy cycle; the following edge
            // both drops Busy and commits the result.
            if (cnt_q <= 5'd1) begin
               state_d   = StIdle;
               cnt_d     = 5'd0;
               pend_wr_d = 1'b0;
               if (pend_wr_q) begin
                  hi_d = pend_q[63:32];
                  lo_d = pend_q[31:0];
               end
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end

         default: begin
            state_d   = StIdle;
            cnt_d     = 5'd0;
            pend_wr_d = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= 5'd0;
         pend_q    <= 64'd0;
         pend_wr_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign Busy  = (state_q != StIdle);
   assign HI    = hi_q;
   assign LO    = lo_q;
   assign MDOut = ReadSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed testbench for mult_div_unit. Inputs change just after the falling
// edge; outputs are sampled at the falling edge, half a cycle after the
// rising edge that updated them. Expected HI/LO are tracked in hi_m / lo_m.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        Start;
   logic [2:0]  MDUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        ReadSel;
   logic        Busy;
   logic [31:0] MDOut;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

   mult_div_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .Start  (Start),
      .MDUOp  (MDUOp),
      .A      (A),
      .B      (B),
      .ReadSel(ReadSel),
      .Busy   (Busy),
      .MDOut  (MDOut),
      .HI     (HI),
      .LO     (LO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Issue one op, wait out Busy, check duration, hold behaviour and result.
   // Returns at the falling edge right after the completion edge, so a
   // following call issues back-to-back.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int ncyc, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input string name);
      int busy_n;
      Start = 1'b1; MDUOp = op; A = a; B = b; ReadSel = 1'b0;
      @(negedge clk);
      Start = 1'b0; MDUOp = 3'd0;
      busy_n = 0;
      while (Busy === 1'b1 && busy_n < 40) begin
         n_tests++;
         if (HI !== hi_m || LO !== lo_m || MDOut !== lo_m) begin
            n_fail++;
            $display("FAIL %s_hold cyc%0d: HI=%h LO=%h MDOut=%h, want HI=%h LO=%h MDOut=%h",
                     name, busy_n, HI, LO, MDOut, hi_m, lo_m, lo_m);
         end
         busy_n++;
         @(negedge clk);
      end
      n_tests++;
      if (busy_n !== ncyc) begin
         n_fail++;
         $display("FAIL %s_busy_len: got %0d cycles, want %0d", name, busy_n, ncyc);
      end
      hi_m = exp_hi;
      lo_m = exp_lo;
      n_tests++;
      if (HI !== hi_m || LO !== lo_m) begin
         n_fail++;
         $display("FAIL %s_result: HI=%h LO=%h, want HI=%h LO=%h", name, HI, LO, hi_m, lo_m);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0; ReadSel = 1'b0;
      #3;
      n_tests++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MDOut !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: Busy=%b HI=%h LO=%h MDOut=%h, want all zero",
                  Busy, HI, LO, MDOut);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_mult();
      run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
      @(negedge clk);
      run_op(3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
      @(negedge clk);
   endtask

   task automatic test_div();
      run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
      @(negedge clk);
      run_op(3'd4, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003, "divu");
      @(negedge clk);
   endtask

   task automatic test_mthi_mtlo();
      Start = 1'b1; MDUOp = 3'd5; A = 32'h1234_5678;
      @(negedge clk);
      MDUOp = 3'd6; A = 32'h9ABC_DEF0;
      n_tests++;
      if (Busy !== 1'b0 || HI !== 32'h1234_5678 || LO !== lo_m) begin
         n_fail++;
         $display("FAIL mthi: Busy=%b HI=%h LO=%h, want Busy=0 HI=12345678 LO=%h",
                  Busy, HI, LO, lo_m);
      end
      @(negedge clk);
      Start = 1'b0; MDUOp = 3'd0;
      hi_m = 32'h1234_5678; lo_m = 32'h9ABC_DEF0;
      n_tests++;
      if (Busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
         n_fail++;
         $display("FAIL mtlo: Busy=%b HI=%h LO=%h, want Busy=0 HI=%h LO=%h",
                  Busy, HI, LO, hi_m, lo_m);
      end
      ReadSel = 1'b1;
      #1;
      n_tests++;
      if (MDOut !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL mdout_hi: got %h, want 12345678", MDOut);
      end
      ReadSel = 1'b0;
      #1;
      n_tests++;
      if (MDOut !== 32'h9ABC_DEF0) begin
         n_fail++;
         $display("FAIL mdout_lo: got %h, want 9abcdef0", MDOut);
      end
      @(negedge clk);
   endtask

   task automatic test_none_ops();
      Start = 1'b1; MDUOp = 3'd0; A = 32'hDEAD_BEEF; B = 32'h1;
      @(negedge clk);
      MDUOp = 3'd7;
      @(negedge clk);
      Start = 1'b0;
      n_tests++;
      if (Busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
         n_fail++;
         $display("FAIL none_ops: Busy=%b HI=%h LO=%h, want Busy=0 HI=%h LO=%h",
                  Busy, HI, LO, hi_m, lo_m);
      end
   endtask

   task automatic test_busy_ignore();
      int busy_n;
      Start = 1'b1; MDUOp = 3'd1; A = 32'd3; B = 32'd5;
      @(negedge clk);
      Start = 1'b0; MDUOp = 3'd0;
      @(negedge clk);
      // MTLO presented while busy must be dropped
      Start = 1'b1; MDUOp = 3'd6; A = 32'h1;
      @(negedge clk);
      Start = 1'b0; MDUOp = 3'd0;
      busy_n = 0;
      while (Busy === 1'b1 && busy_n < 40) begin
         busy_n++;
         @(negedge clk);
      end
      hi_m = 32'd0; lo_m = 32'd15;
      n_tests++;
      if (HI !== hi_m || LO !== lo_m) begin
         n_fail++;
         $display("FAIL busy_ignore: HI=%h LO=%h, want HI=%h LO=%h", HI, LO, hi_m, lo_m);
      end
      @(negedge clk);
      // divide by zero: full duration, HI/LO untouched
      run_op(3'd3, 32'h0000_1234, 32'h0, 10, hi_m, lo_m, "div0");
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      Start = 1'b1; MDUOp = 3'd5; A = 32'hAAAA_5555;
      @(negedge clk);
      Start = 1'b1; MDUOp = 3'd3; A = 32'd100; B = 32'd3;
      @(negedge clk);
      Start = 1'b0; MDUOp = 3'd0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      hi_m = 32'd0; lo_m = 32'd0;
      n_tests++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MDOut !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid: Busy=%b HI=%h LO=%h MDOut=%h, want all zero",
                  Busy, HI, LO, MDOut);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_tests++;
         if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stale cyc%0d: Busy=%b HI=%h LO=%h, want all zero",
                     i, Busy, HI, LO);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "b2b_mult");
      run_op(3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, "b2b_divu");
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, "div_ovf");
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_none_ops();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
